// File: rtl/mem_bank_if.sv
// Bus bundle for mem_bank: write controls, parallel data, drain handshake and status.
// Parity signals exist only when MEM_BANK_PARITY_EN is defined.
interface mem_bank_if #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned AW     = $clog2(NUM_CH)
);
  logic                    load;
  logic [WIDTH*NUM_CH-1:0] d_flat;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic                    shift_en;
  logic [WIDTH*NUM_CH-1:0] q_flat;
  logic [NUM_CH-1:0]       vld;
  logic                    full;
  logic                    drain_start;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
`ifdef MEM_BANK_PARITY_EN
  logic                    inj_err;
  logic                    par_err;
`endif

  // Producer/consumer side
  modport master (
`ifdef MEM_BANK_PARITY_EN
    output inj_err,
    input  par_err,
`endif
    output load, d_flat, wr_en, wr_addr, wr_data, shift_en, drain_start, out_ready,
    input  q_flat, vld, full, out_data, out_valid, busy
  );

  // Register bank side
  modport slave (
`ifdef MEM_BANK_PARITY_EN
    input  inj_err,
    output par_err,
`endif
    input  load, d_flat, wr_en, wr_addr, wr_data, shift_en, drain_start, out_ready,
    output q_flat, vld, full, out_data, out_valid, busy
  );
endinterface

// File: rtl/mem_bank.sv
// Parametrised register bank: parallel load, shift-in, addressed write and serial drain.
// Optional per-channel even parity with error injection under MEM_BANK_PARITY_EN.
module mem_bank #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned AW     = $clog2(NUM_CH)
) (
  input  logic      clk,
  input  logic      clr_n,
  mem_bank_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  ch_q [NUM_CH];
  logic [WIDTH-1:0]  ch_d [NUM_CH];
  logic [NUM_CH-1:0] vld_q, vld_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] scan;
  logic              nxt_hit;
  logic [AW-1:0]     nxt_idx;
  logic [WIDTH-1:0]  nxt_data;

`ifdef MEM_BANK_PARITY_EN
  logic [NUM_CH-1:0] par_q, par_d;
  logic              par_err_q, par_err_d;
  logic              nxt_par;
`endif

  // Write paths, beat selection and drain FSM next-state
  always_comb begin
    ch_d        = ch_q;
    vld_d       = vld_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    scan        = vld_q;
    nxt_hit     = 1'b0;
    nxt_idx     = '0;
    nxt_data    = '0;
`ifdef MEM_BANK_PARITY_EN
    par_d       = par_q;
    par_err_d   = par_err_q;
    nxt_par     = 1'b0;
`endif

    if (!busy_q) begin
      if (bus.load) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          ch_d[i] = bus.d_flat[i*WIDTH +: WIDTH];
`ifdef MEM_BANK_PARITY_EN
          par_d[i] = (^bus.d_flat[i*WIDTH +: WIDTH]) ^ bus.inj_err;
`endif
        end
        vld_d = '1;
      end else if (bus.shift_en) begin
        for (int i = 1; i < int'(NUM_CH); i++) begin
          ch_d[i] = ch_q[i-1];
`ifdef MEM_BANK_PARITY_EN
          par_d[i] = par_q[i-1];
`endif
        end
        ch_d[0] = bus.wr_data;
        vld_d   = {vld_q[NUM_CH-2:0], 1'b1};
`ifdef MEM_BANK_PARITY_EN
        par_d[0] = (^bus.wr_data) ^ bus.inj_err;
`endif
      end else if (bus.wr_en) begin
        // Addresses at or above NUM_CH match no channel and leave state untouched
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (AW'(i) == bus.wr_addr) begin
            ch_d[i]  = bus.wr_data;
            vld_d[i] = 1'b1;
`ifdef MEM_BANK_PARITY_EN
            par_d[i] = (^bus.wr_data) ^ bus.inj_err;
`endif
          end
        end
      end
    end

    // While sending, the current beat's flag is excluded so the scan finds the next one
    if (state_q == SEND) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (AW'(i) == ptr_q) scan[i] = 1'b0;
      end
    end

    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (scan[i]) begin
        nxt_hit  = 1'b1;
        nxt_idx  = AW'(i);
        nxt_data = ch_q[i];
`ifdef MEM_BANK_PARITY_EN
        nxt_par  = par_q[i];
`endif
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.drain_start && nxt_hit) begin
          state_d     = SEND;
          ptr_d       = nxt_idx;
          out_data_d  = nxt_data;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
`ifdef MEM_BANK_PARITY_EN
          par_err_d   = nxt_par ^ (^nxt_data);
`endif
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          vld_d = scan;
          if (nxt_hit) begin
            ptr_d      = nxt_idx;
            out_data_d = nxt_data;
`ifdef MEM_BANK_PARITY_EN
            par_err_d  = nxt_par ^ (^nxt_data);
`endif
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b0;
`ifdef MEM_BANK_PARITY_EN
            par_err_d   = 1'b0;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < int'(NUM_CH); i++) ch_q[i] <= '0;
      vld_q       <= '0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_BANK_PARITY_EN
      par_q       <= '0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < int'(NUM_CH); i++) ch_q[i] <= ch_d[i];
      vld_q       <= vld_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MEM_BANK_PARITY_EN
      par_q       <= par_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_qflat
    assign bus.q_flat[g*WIDTH +: WIDTH] = ch_q[g];
  end

  assign bus.vld       = vld_q;
  assign bus.full      = &vld_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
`ifdef MEM_BANK_PARITY_EN
  assign bus.par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_mem_bank.sv
// Directed self-checking bench for mem_bank (6 channels x 5 bits).
module tb_mem_bank;
  localparam int unsigned WIDTH  = 5;
  localparam int unsigned NUM_CH = 6;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  int checks = 0;
  int failures = 0;

  logic [WIDTH*NUM_CH-1:0] pat;
  logic [WIDTH*NUM_CH-1:0] exp_q;

  mem_bank_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

  mem_bank #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load = 1'b0; bus.d_flat = '0; bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.shift_en = 1'b0; bus.drain_start = 1'b0; bus.out_ready = 1'b0;
`ifdef MEM_BANK_PARITY_EN
    bus.inj_err = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.q_flat !== '0) begin failures++; $display("FAIL reset_q: got %h want 0", bus.q_flat); end
    checks++; if (bus.vld !== 6'b0) begin failures++; $display("FAIL reset_vld: got %b want 000000", bus.vld); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if ({bus.out_valid, bus.busy, bus.out_data} !== 7'b0) begin failures++;
      $display("FAIL reset_out: got v=%b b=%b d=%h want 0", bus.out_valid, bus.busy, bus.out_data); end
  endtask

  task automatic test_load();
    do_reset();
    bus.d_flat = pat; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    checks++; if (bus.q_flat !== pat) begin failures++; $display("FAIL load_q: got %h want %h", bus.q_flat, pat); end
    checks++; if (bus.vld !== 6'b111111) begin failures++; $display("FAIL load_vld: got %b want 111111", bus.vld); end
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL load_full: got %b want 1", bus.full); end
  endtask

  task automatic test_shift();
    do_reset();
    bus.shift_en = 1'b1;
    bus.wr_data = 5'd7; tick();
    bus.wr_data = 5'd8; tick();
    bus.wr_data = 5'd9; tick();
    bus.shift_en = 1'b0;
    exp_q = {5'd0, 5'd0, 5'd0, 5'd7, 5'd8, 5'd9};
    checks++; if (bus.q_flat !== exp_q) begin failures++; $display("FAIL shift_q: got %h want %h", bus.q_flat, exp_q); end
    checks++; if (bus.vld !== 6'b000111) begin failures++; $display("FAIL shift_vld: got %b want 000111", bus.vld); end
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL shift_full: got %b want 0", bus.full); end
  endtask

  task automatic test_wr_en();
    do_reset();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 5'h1F;
    tick();
    exp_q = {5'd0, 5'h1F, 5'd0, 5'd0, 5'd0, 5'd0};
    checks++; if (bus.q_flat !== exp_q) begin failures++; $display("FAIL wr4_q: got %h want %h", bus.q_flat, exp_q); end
    checks++; if (bus.vld !== 6'b010000) begin failures++; $display("FAIL wr4_vld: got %b want 010000", bus.vld); end
    bus.wr_addr = 3'd6; bus.wr_data = 5'h0A;
    tick();
    bus.wr_addr = 3'd7;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.q_flat !== exp_q) begin failures++; $display("FAIL wr_oob_q: got %h want %h", bus.q_flat, exp_q); end
    checks++; if (bus.vld !== 6'b010000) begin failures++; $display("FAIL wr_oob_vld: got %b want 010000", bus.vld); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.d_flat = pat; bus.load = 1'b1; bus.shift_en = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 5'h1F;
    tick();
    checks++; if (bus.q_flat !== pat) begin failures++; $display("FAIL prio_load: got %h want %h", bus.q_flat, pat); end
    bus.load = 1'b0; bus.wr_addr = 3'd3;
    tick();
    idle_inputs();
    exp_q = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'h1F};
    checks++; if (bus.q_flat !== exp_q) begin failures++; $display("FAIL prio_shift: got %h want %h", bus.q_flat, exp_q); end
    checks++; if (bus.vld !== 6'b111111) begin failures++; $display("FAIL prio_vld: got %b want 111111", bus.vld); end
  endtask

  task automatic test_drain_stall();
    do_reset();
    bus.wr_en = 1'b1;
    bus.wr_addr = 3'd0; bus.wr_data = 5'd3; tick();
    bus.wr_addr = 3'd2; bus.wr_data = 5'd5; tick();
    bus.wr_addr = 3'd5; bus.wr_data = 5'd7; tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.vld !== 6'b100101) begin failures++; $display("FAIL ds_vld0: got %b want 100101", bus.vld); end
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    checks++; if ({bus.out_valid, bus.busy, bus.out_data} !== {2'b11, 5'd3}) begin failures++;
      $display("FAIL ds_first: got v=%b b=%b d=%0d want v=1 b=1 d=3", bus.out_valid, bus.busy, bus.out_data); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 5'd3}) begin failures++;
        $display("FAIL ds_stall%0d: got v=%b d=%0d want v=1 d=3", k, bus.out_valid, bus.out_data); end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 5'd5}) begin failures++;
      $display("FAIL ds_beat2: got v=%b d=%0d want v=1 d=5", bus.out_valid, bus.out_data); end
    checks++; if (bus.vld !== 6'b100100) begin failures++; $display("FAIL ds_vld1: got %b want 100100", bus.vld); end
    tick();
    checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 5'd7}) begin failures++;
      $display("FAIL ds_beat3: got v=%b d=%0d want v=1 d=7", bus.out_valid, bus.out_data); end
    tick();
    checks++; if ({bus.out_valid, bus.busy} !== 2'b01) begin failures++;
      $display("FAIL ds_done: got v=%b b=%b want v=0 b=1", bus.out_valid, bus.busy); end
    bus.out_ready = 1'b0;
    tick();
    checks++; if ({bus.busy, bus.vld} !== 7'b0) begin failures++;
      $display("FAIL ds_idle: got b=%b vld=%b want 0 000000", bus.busy, bus.vld); end
    exp_q = {5'd7, 5'd0, 5'd0, 5'd5, 5'd0, 5'd3};
    checks++; if (bus.q_flat !== exp_q) begin failures++; $display("FAIL ds_data_kept: got %h want %h", bus.q_flat, exp_q); end
  endtask

  task automatic test_back_to_back_blocked();
    do_reset();
    bus.d_flat = pat; bus.load = 1'b1;
    tick();
    bus.load = 1'b0; bus.drain_start = 1'b1;
    tick();
    bus.out_ready = 1'b1; bus.load = 1'b1; bus.d_flat = ~pat; bus.shift_en = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 5'h1E;
    for (int k = 0; k < 6; k++) begin
      checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, 5'(k + 1)}) begin failures++;
        $display("FAIL bb_beat%0d: got v=%b d=%0d want v=1 d=%0d", k, bus.out_valid, bus.out_data, k + 1); end
      tick();
    end
    checks++; if ({bus.out_valid, bus.busy} !== 2'b01) begin failures++;
      $display("FAIL bb_done: got v=%b b=%b want v=0 b=1", bus.out_valid, bus.busy); end
    idle_inputs();
    tick();
    checks++; if (bus.q_flat !== pat) begin failures++; $display("FAIL bb_blocked_q: got %h want %h", bus.q_flat, pat); end
    checks++; if ({bus.busy, bus.vld} !== 7'b0) begin failures++;
      $display("FAIL bb_idle: got b=%b vld=%b want 0 000000", bus.busy, bus.vld); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.d_flat = pat; bus.load = 1'b1;
    tick();
    bus.load = 1'b0; bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL ar_pre: got v=%b want 1", bus.out_valid); end
    #2;
    clr_n = 1'b0;
    #1;
    checks++; if ({bus.out_valid, bus.busy, bus.out_data} !== 7'b0) begin failures++;
      $display("FAIL ar_out: got v=%b b=%b d=%h want 0", bus.out_valid, bus.busy, bus.out_data); end
    checks++; if ({bus.q_flat, bus.vld} !== '0) begin failures++;
      $display("FAIL ar_state: got q=%h vld=%b want 0", bus.q_flat, bus.vld); end
    @(negedge clk);
    clr_n = 1'b1;
    bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    checks++; if ({bus.out_valid, bus.busy} !== 2'b00) begin failures++;
      $display("FAIL ar_empty_drain: got v=%b b=%b want 0 0", bus.out_valid, bus.busy); end
  endtask

`ifdef MEM_BANK_PARITY_EN
  task automatic test_parity();
    do_reset();
    bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 5'h03; bus.inj_err = 1'b1;
    tick();
    bus.wr_addr = 3'd2; bus.wr_data = 5'h04; bus.inj_err = 1'b0;
    tick();
    bus.wr_en = 1'b0; bus.drain_start = 1'b1;
    tick();
    bus.drain_start = 1'b0;
    checks++; if ({bus.out_valid, bus.out_data, bus.par_err} !== {1'b1, 5'h03, 1'b1}) begin failures++;
      $display("FAIL par_beat1: got v=%b d=%h pe=%b want 1 03 1", bus.out_valid, bus.out_data, bus.par_err); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if ({bus.out_valid, bus.out_data, bus.par_err} !== {1'b1, 5'h04, 1'b0}) begin failures++;
      $display("FAIL par_beat2: got v=%b d=%h pe=%b want 1 04 0", bus.out_valid, bus.out_data, bus.par_err); end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.par_err !== 1'b0) begin failures++; $display("FAIL par_done: got %b want 0", bus.par_err); end
    tick();
  endtask
`endif

  initial begin
    pat = {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    exp_q = '0;
    test_reset();
    test_load();
    test_shift();
    test_wr_en();
    test_priority();
    test_drain_stall();
    test_back_to_back_blocked();
    test_async_reset();
`ifdef MEM_BANK_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish want finish before 50000");
    $fatal(1);
  end
endmodule
